branch_redirect: RTL and testbench
==================================

BRANCH_REDIRECT -- requirements
Module: branch_redirect

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, the number of cycles `flush` is held after a redirect is accepted (range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port ex_valid, input, 1, the EX-stage instruction is valid.
REQ-005 SHALL have port ex_ready, output, 1, the block accepts an EX instruction this cycle.
REQ-006 SHALL have port ex_inst, input, 32, the EX-stage instruction word.
REQ-007 SHALL have port ex_pc, input, 32, the PC of the EX instruction.
REQ-008 SHALL have ports rs1_val and rs2_val, input, 32 each, the forwarded operand values.
REQ-009 SHALL have port redir_valid, output, 1, a fetch redirect request is pending.
REQ-010 SHALL have port redir_ready, input, 1, fetch accepts the redirect.
REQ-011 SHALL have port redir_pc, output, 32, the redirect target address.
REQ-012 SHALL have port link_val, output, 32, the registered pc+4 of the last accepted JAL/JALR.
REQ-013 SHALL have port flush, output, 1, kill the IF/ID instructions younger than the redirect.

Function
REQ-014 SHALL implement the FSM states IDLE, REDIR and FLUSH; ex_ready=1 only in IDLE.
REQ-015 SHALL accept an instruction on the rising edge where ex_valid & ex_ready, decoding it by opcode ex_inst[6:0].
REQ-016 SHALL resolve B-type (1100011) by funct3: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; funct3 010/011 SHALL resolve not-taken.
REQ-017 SHALL compute the branch target as ex_pc + sign-extended B-immediate (13 bits, bit0=0), mod 2^32.
REQ-018 SHALL treat JAL (1101111) as always taken, with target ex_pc + sign-extended J-immediate (21 bits) and link_val = ex_pc+4.
REQ-019 SHALL treat JALR (1100111) as always taken, with target (rs1_val + sign-extended I-immediate) & ~1 and link_val = ex_pc+4.
REQ-020 SHALL leave state IDLE and outputs unchanged for a not-taken branch or any other opcode (predict-not-taken policy).
REQ-021 SHALL, for a taken instruction, register redir_pc and go to REDIR, with redir_valid=1 from the next cycle (1-cycle latency).
REQ-022 SHALL hold redir_valid and redir_pc stable in REDIR until redir_ready=1, then go to FLUSH.
REQ-023 SHALL drive flush=1 for exactly FLUSH_CYCLES cycles in FLUSH, counted by an internal down-counter, then return to IDLE.
REQ-024 SHALL ignore ex_valid while in REDIR or FLUSH, with no state change.
REQ-025 SHALL add all addresses with 32-bit wrap-around and no overflow detection.

Reset
REQ-026 SHALL, on rst=1, immediately force IDLE, redir_valid=0, redir_pc=0, link_val=0, flush=0 and counter=0, including mid-REDIR or mid-FLUSH.
REQ-027 SHALL, after rst deasserts, accept an instruction on the first clock edge with ex_valid=1.

Configuration
REQ-028 SHALL, when BR_STATS_EN is defined, add a 16-bit output taken_cnt, reset to 0, that increments on each accepted redirect (redir_valid & redir_ready) and saturates at 0xFFFF.
REQ-029 SHALL, when BR_STATS_EN is undefined, omit the taken_cnt port and its logic entirely.

Structure
REQ-030 SHALL place the opcode constants (BRANCH, JAL, JALR), the funct3 encodings and the FSM state encoding in the shared package riscv_pkg.
REQ-031 SHALL contain one sub-module, br_cmp, a combinational funct3/operand comparator producing a taken flag.

Verification
REQ-032 SHALL test BEQ: ex_pc=0x100, rs1=rs2=5, imm=+16 -> next cycle redir_valid=1, redir_pc=0x110; with redir_ready=1, flush high for 2 cycles.
REQ-033 SHALL test BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not-taken (redir_valid stays 0).
REQ-034 SHALL test JALR: rs1=0x2003, imm=+4, ex_pc=0x40 -> redir_pc=0x2006, link_val=0x44.
REQ-035 SHALL test backpressure: redir_ready=0 for 5 cycles -> redir_valid and redir_pc held and ex_ready=0 throughout; a new ex_valid during this window is ignored.
REQ-036 SHALL test reset mid-FLUSH: rst pulsed in the 1st flush cycle -> flush=0 and redir_valid=0 immediately, IDLE thereafter.
REQ-037 SHALL test wrap-around: JAL at ex_pc=0xFFFFFFF8, imm=+16 -> redir_pc=0x00000008.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared RV32 constants for the branch redirect block.
//   Holds the control-transfer opcodes (BRANCH, JAL, JALR), the B-type
//   funct3 comparison encodings, and the redirect FSM state encoding.
//   This package has no ports.
package riscv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/br_cmp.sv
// br_cmp -- combinational branch condition evaluator.
//   funct3 : B-type comparison select
//   rs1    : first operand (32 bits)
//   rs2    : second operand (32 bits)
//   taken  : 1 when the selected condition holds; reserved funct3 codes
//            (010, 011) never resolve taken
module br_cmp
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;

  assign rs1_s = $signed(rs1);
  assign rs2_s = $signed(rs2);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = (rs1_s <  rs2_s);
      F3_BGE:  taken = (rs1_s >= rs2_s);
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect.sv
// branch_redirect -- EX-stage branch/jump resolution and fetch redirect.
//   Predict-not-taken: a taken B-type, JAL or JALR raises a redirect to
//   fetch one cycle after acceptance, holds it until fetch accepts, then
//   asserts flush for FLUSH_CYCLES cycles to kill younger IF/ID work.
//
//   Parameter FLUSH_CYCLES (1..15): number of cycles flush stays high.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     ex_valid/ex_ready EX instruction handshake (ready only when idle)
//     ex_inst, ex_pc    instruction word and its PC
//     rs1_val, rs2_val  forwarded operands
//     redir_valid/redir_ready/redir_pc  redirect request to fetch
//     link_val          registered pc+4 of the last accepted JAL/JALR
//     flush             kill IF/ID instructions younger than the redirect
//     taken_cnt         (only with BR_STATS_EN defined) saturating 16-bit
//                       count of redirects accepted by fetch
//
//   Build option: define BR_STATS_EN to add the taken_cnt port and counter.
module branch_redirect
  import riscv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [31:0] redir_pc,
  output logic [31:0] link_val,
  output logic        flush
`ifdef BR_STATS_EN
  ,
  output logic [15:0] taken_cnt
`endif
);

  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_j;
  logic signed [31:0] imm_i;
  logic [31:0]        br_target;
  logic [31:0]        jal_target;
  logic [31:0]        jalr_target;
  logic [31:0]        target;
  logic [31:0]        link_next;
  logic               is_branch;
  logic               is_jal;
  logic               is_jalr;
  logic               br_taken;
  logic               take;
  logic               accept;

  state_t             state_q;
  state_t             state_d;
  logic [3:0]         cnt_q;
  logic [3:0]         cnt_d;

  // Decode and target generation (combinational, EX stage)
  assign opcode = ex_inst[6:0];
  assign funct3 = ex_inst[14:12];

  assign imm_b = {{19{ex_inst[31]}}, ex_inst[31], ex_inst[7],
                  ex_inst[30:25], ex_inst[11:8], 1'b0};
  assign imm_j = {{11{ex_inst[31]}}, ex_inst[31], ex_inst[19:12],
                  ex_inst[20], ex_inst[30:21], 1'b0};
  assign imm_i = {{20{ex_inst[31]}}, ex_inst[31:20]};

  // All address sums wrap modulo 2^32; no overflow is reported.
  assign br_target   = ex_pc + $unsigned(imm_b);
  assign jal_target  = ex_pc + $unsigned(imm_j);
  assign jalr_target = (rs1_val + $unsigned(imm_i)) & ~32'd1;
  assign link_next   = ex_pc + 32'd4;

  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);

  br_cmp u_br_cmp (
    .funct3 (funct3),
    .rs1    (rs1_val),
    .rs2    (rs2_val),
    .taken  (br_taken)
  );

  assign take   = (is_branch & br_taken) | is_jal | is_jalr;
  assign accept = ex_valid & ex_ready;

  always_comb begin
    target = br_target;
    if (is_jal) begin
      target = jal_target;
    end else if (is_jalr) begin
      target = jalr_target;
    end
  end

  // Redirect FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ex_ready    = 1'b0;
    redir_valid = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid && take) begin
          state_d = ST_REDIR;
        end
      end
      ST_REDIR: begin
        redir_valid = 1'b1;
        if (redir_ready) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_CNT;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        // The cycle in which the count reaches 1 is the last flush cycle.
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Redirect target and link registers, loaded only on a taken accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_pc <= 32'd0;
      link_val <= 32'd0;
    end else if (accept && take) begin
      redir_pc <= target;
      if (is_jal || is_jalr) begin
        link_val <= link_next;
      end
    end
  end

`ifdef BR_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt <= 16'd0;
    end else if (redir_valid && redir_ready) begin
      taken_cnt <= sat_inc(taken_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect -- self-checking bench for branch_redirect (default
// build, FLUSH_CYCLES = 2). Inputs change on the falling clock edge; the
// redirect scoreboard samples shortly after each falling edge.
module tb_branch_redirect;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic [31:0] link_val;
  logic        flush;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  branch_redirect #(.FLUSH_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_inst     (ex_inst),
    .ex_pc       (ex_pc),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .redir_valid (redir_valid),
    .redir_ready (redir_ready),
    .redir_pc    (redir_pc),
    .link_val    (link_val),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every redirect accepted by fetch must match the oldest
  // expected target pushed when the instruction was driven.
  always begin
    @(negedge clk);
    #2;
    if (!rst && redir_valid && redir_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected redirect to %h", redir_pc);
      end else begin
        sb_exp = exp_q.pop_front();
        if (redir_pc !== sb_exp) begin
          errors++;
          $display("FAIL scoreboard redir_pc: got %h want %h", redir_pc, sb_exp);
        end
      end
    end
  end

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  // Present one instruction for a single cycle; called on a falling edge,
  // returns on the falling edge after the accepting rising edge.
  task automatic drive_ex(input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1;
    ex_inst  = inst;
    ex_pc    = pc;
    rs1_val  = a;
    rs2_val  = b;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  // Accept the pending redirect and count the flush cycles that follow.
  task automatic handshake(output int n);
    redir_ready = 1'b1;
    @(negedge clk);
    redir_ready = 1'b0;
    n = 0;
    while (flush && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ex_valid = 1'b0;
    redir_ready = 1'b0;
    ex_inst = 32'd0;
    ex_pc = 32'd0;
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset ex_ready: got %b want 1", ex_ready); end
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL reset redir_valid: got %b want 0", redir_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset flush: got %b want 0", flush); end
    checks++; if (redir_pc !== 32'd0) begin errors++; $display("FAIL reset redir_pc: got %h want 0", redir_pc); end
    checks++; if (link_val !== 32'd0) begin errors++; $display("FAIL reset link_val: got %h want 0", link_val); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_beq;
    int n;
    exp_q.push_back(32'h110);
    drive_ex(enc_b(3'b000, 13'd16), 32'h100, 32'd5, 32'd5);
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL beq redir_valid: got %b want 1", redir_valid); end
    checks++; if (redir_pc !== 32'h110) begin errors++; $display("FAIL beq redir_pc: got %h want 00000110", redir_pc); end
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL beq ex_ready in REDIR: got %b want 0", ex_ready); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq flush in REDIR: got %b want 0", flush); end
    handshake(n);
    checks++; if (n != 2) begin errors++; $display("FAIL beq flush length: got %0d want 2", n); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL beq ex_ready after flush: got %b want 1", ex_ready); end
  endtask

  task automatic test_blt_bltu;
    int n;
    exp_q.push_back(32'h1F8);
    drive_ex(enc_b(3'b100, 13'h1FF8), 32'h200, 32'hFFFFFFFF, 32'd1);
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL blt taken: got %b want 1", redir_valid); end
    handshake(n);
    checks++; if (n != 2) begin errors++; $display("FAIL blt flush length: got %0d want 2", n); end
    drive_ex(enc_b(3'b110, 13'h1FF8), 32'h200, 32'hFFFFFFFF, 32'd1);
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL bltu not-taken: got %b want 0", redir_valid); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL bltu ex_ready: got %b want 1", ex_ready); end
    @(negedge clk);
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL bltu stays idle: got %b want 0", redir_valid); end
  endtask

  // Remaining funct3 codes and a non-control opcode; expected taken flag
  // is written directly in the table.
  task automatic test_funct3;
    logic [2:0]  f3 [10] = '{3'b000, 3'b001, 3'b001, 3'b101, 3'b101,
                             3'b111, 3'b111, 3'b010, 3'b011, 3'b110};
    logic [31:0] a  [10] = '{32'd7, 32'd7, 32'd7, 32'hFFFFFFFE, 32'd5,
                             32'hFFFFFFFE, 32'd0, 32'd3, 32'd1, 32'd1};
    logic [31:0] b  [10] = '{32'd8, 32'd7, 32'd8, 32'd1, 32'd5,
                             32'd1, 32'd1, 32'd3, 32'd2, 32'd2};
    logic        tk [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                             1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int n;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] pc;
      pc = 32'h300 + 32'(i) * 32'h10;
      if (tk[i]) exp_q.push_back(pc + 32'd32);
      drive_ex(enc_b(f3[i], 13'd32), pc, a[i], b[i]);
      checks++;
      if (redir_valid !== tk[i]) begin
        errors++;
        $display("FAIL funct3 %b case %0d: redir_valid got %b want %b", f3[i], i, redir_valid, tk[i]);
      end
      if (tk[i]) handshake(n);
    end
    drive_ex(32'h00500093, 32'h400, 32'd0, 32'd0);
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL other opcode: redir_valid got %b want 0", redir_valid); end
  endtask

  task automatic test_jalr;
    int n;
    exp_q.push_back(32'h2006);
    drive_ex(enc_jalr(12'd4), 32'h40, 32'h2003, 32'd0);
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL jalr redir_valid: got %b want 1", redir_valid); end
    checks++; if (redir_pc !== 32'h2006) begin errors++; $display("FAIL jalr redir_pc: got %h want 00002006", redir_pc); end
    checks++; if (link_val !== 32'h44) begin errors++; $display("FAIL jalr link_val: got %h want 00000044", link_val); end
    handshake(n);
    checks++; if (n != 2) begin errors++; $display("FAIL jalr flush length: got %0d want 2", n); end
  endtask

  task automatic test_backpressure;
    int n;
    exp_q.push_back(32'h1100);
    drive_ex(enc_j(21'h100), 32'h1000, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL bp cycle %0d redir_valid: got %b want 1", i, redir_valid); end
      checks++; if (redir_pc !== 32'h1100) begin errors++; $display("FAIL bp cycle %0d redir_pc: got %h want 00001100", i, redir_pc); end
      checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL bp cycle %0d ex_ready: got %b want 0", i, ex_ready); end
      if (i == 1) begin
        ex_valid = 1'b1;
        ex_inst  = enc_j(21'h40);
        ex_pc    = 32'h3000;
      end
      if (i == 3) ex_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (link_val !== 32'h1004) begin errors++; $display("FAIL bp link_val: got %h want 00001004", link_val); end
    handshake(n);
    checks++; if (n != 2) begin errors++; $display("FAIL bp flush length: got %0d want 2", n); end
    @(negedge clk);
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL bp ignored instr redirected: got %b want 0", redir_valid); end
    checks++; if (link_val !== 32'h1004) begin errors++; $display("FAIL bp link_val after: got %h want 00001004", link_val); end
  endtask

  task automatic test_reset_mid_flush;
    exp_q.push_back(32'h110);
    drive_ex(enc_b(3'b000, 13'd16), 32'h100, 32'd9, 32'd9);
    redir_ready = 1'b1;
    @(negedge clk);
    redir_ready = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rstflush first flush cycle: got %b want 1", flush); end
    rst = 1'b1;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstflush flush: got %b want 0", flush); end
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL rstflush redir_valid: got %b want 0", redir_valid); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rstflush ex_ready: got %b want 1", ex_ready); end
    checks++; if (redir_pc !== 32'd0) begin errors++; $display("FAIL rstflush redir_pc: got %h want 0", redir_pc); end
    checks++; if (link_val !== 32'd0) begin errors++; $display("FAIL rstflush link_val: got %h want 0", link_val); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstflush idle flush: got %b want 0", flush); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rstflush idle ex_ready: got %b want 1", ex_ready); end
  endtask

  task automatic test_wrap;
    int n;
    exp_q.push_back(32'h8);
    drive_ex(enc_j(21'd16), 32'hFFFFFFF8, 32'd0, 32'd0);
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL wrap redir_valid: got %b want 1", redir_valid); end
    checks++; if (redir_pc !== 32'h8) begin errors++; $display("FAIL wrap redir_pc: got %h want 00000008", redir_pc); end
    checks++; if (link_val !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap link_val: got %h want fffffffc", link_val); end
    handshake(n);
    checks++; if (n != 2) begin errors++; $display("FAIL wrap flush length: got %0d want 2", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    exp_q.push_back(32'h500);
    drive_ex(enc_j(21'h100), 32'h400, 32'd0, 32'd0);
    handshake(n);
    exp_q.push_back(32'h620);
    drive_ex(enc_j(21'h20), 32'h600, 32'd0, 32'd0);
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL b2b redir_valid: got %b want 1", redir_valid); end
    checks++; if (redir_pc !== 32'h620) begin errors++; $display("FAIL b2b redir_pc: got %h want 00000620", redir_pc); end
    checks++; if (link_val !== 32'h604) begin errors++; $display("FAIL b2b link_val: got %h want 00000604", link_val); end
    handshake(n);
    checks++; if (n != 2) begin errors++; $display("FAIL b2b flush length: got %0d want 2", n); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blt_bltu();
    test_funct3();
    test_jalr();
    test_backpressure();
    test_reset_mid_flush();
    test_wrap();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d redirects outstanding, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
